spi_tra_buffer_fifo: RTL and testbench

Parametrised transmit buffer between the Object Dictionary/SCB side and the SPI master. It queues up to DEPTH packed SPI transaction words and splits the head word into id, select, register and data fields. The head word is presented to the SPI master with a valid/ready handshake. It replaces the single-entry, fixed-width transmit data register and adds depth, a configurable data width, flow control, overflow detection and flush.

---
 rtl/spi_tra_buffer_fifo.sv | 88 ++++++++
 tb/tb_spi_tra_buffer_fifo.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/spi_tra_buffer_fifo.sv
// Transmit queue between the Object Dictionary/SCB side and the SPI master.
// Holds up to DEPTH packed transaction words and presents the head word, split into fields, with valid/ready.
module spi_tra_buffer_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    localparam int WORD_W = 24 + DATA_W,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] data_tra_in,
    input  logic              buffer_en,
    input  logic              flush,
    input  logic              tra_ready,
    output logic              tra_valid,
    output logic [7:0]        spi_id,
    output logic [7:0]        spi_select,
    output logic [7:0]        spi_reg,
    output logic [DATA_W-1:0] data_tra_out,
    output logic              full,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              overflow_reg;
    logic              pop;
    logic              wr;
    logic              drop;
    logic [WORD_W-1:0] head;

    assign tra_valid = (count_reg != '0);
    assign full      = (count_reg == FULL_CNT);
    assign count     = count_reg;
    assign overflow  = overflow_reg;

    // A pop frees a slot in the same cycle, so a full queue can still accept a write.
    assign pop  = tra_valid & tra_ready;
    assign wr   = buffer_en & (~full | pop);
    assign drop = buffer_en & full & ~pop;

    always_ff @(posedge clk) begin
        if (wr && !flush) begin
            mem[wr_ptr_reg] <= data_tra_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else if (flush) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (wr) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (wr && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop && !wr) begin
                count_reg <= count_reg - 1'b1;
            end
            if (drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Fields are forced to zero when nothing is queued so the master never sees stale data.
    assign head         = tra_valid ? mem[rd_ptr_reg] : '0;
    assign spi_id       = head[WORD_W-1 -: 8];
    assign spi_select   = head[WORD_W-9 -: 8];
    assign spi_reg      = head[WORD_W-17 -: 8];
    assign data_tra_out = head[DATA_W-1:0];
endmodule

// File: tb/tb_spi_tra_buffer_fifo.sv
// Directed bench for spi_tra_buffer_fifo: an 8-bit/depth-4 instance and a 32-bit/depth-8 instance.
module tb_spi_tra_buffer_fifo;
    logic clk;

    logic        a_rst, a_en, a_flush, a_rdy, a_valid, a_full, a_ovf;
    logic [31:0] a_din;
    logic [7:0]  a_id, a_sel, a_reg, a_data;
    logic [2:0]  a_count;

    logic        b_rst, b_en, b_flush, b_rdy, b_valid, b_full, b_ovf;
    logic [55:0] b_din;
    logic [7:0]  b_id, b_sel, b_reg;
    logic [31:0] b_data;
    logic [3:0]  b_count;

    int checks = 0;
    int errors = 0;

    spi_tra_buffer_fifo #(.DATA_W(8), .DEPTH(4)) u_a (
        .clk(clk), .rst(a_rst), .data_tra_in(a_din), .buffer_en(a_en), .flush(a_flush),
        .tra_ready(a_rdy), .tra_valid(a_valid), .spi_id(a_id), .spi_select(a_sel),
        .spi_reg(a_reg), .data_tra_out(a_data), .full(a_full), .count(a_count), .overflow(a_ovf)
    );

    spi_tra_buffer_fifo #(.DATA_W(32), .DEPTH(8)) u_b (
        .clk(clk), .rst(b_rst), .data_tra_in(b_din), .buffer_en(b_en), .flush(b_flush),
        .tra_ready(b_rdy), .tra_valid(b_valid), .spi_id(b_id), .spi_select(b_sel),
        .spi_reg(b_reg), .data_tra_out(b_data), .full(b_full), .count(b_count), .overflow(b_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        a_rst = 1'b0; a_en = 1'b0; a_flush = 1'b0; a_rdy = 1'b0; a_din = '0;
        b_rst = 1'b0; b_en = 1'b0; b_flush = 1'b0; b_rdy = 1'b0; b_din = '0;
        tick();
        tick();
        chk("a_reset_count", a_count, 0);
        chk("a_reset_valid", a_valid, 0);
        chk("a_reset_full", a_full, 0);
        chk("a_reset_ovf", a_ovf, 0);
        chk("a_reset_id", a_id, 0);
        a_rst = 1'b1;
        b_rst = 1'b1;

        // Single write, hold, then pop
        a_din = 32'hA1B2C3D4; a_en = 1'b1;
        tick();
        a_en = 1'b0;
        chk("t1_id", a_id, 8'hA1);
        chk("t1_sel", a_sel, 8'hB2);
        chk("t1_reg", a_reg, 8'hC3);
        chk("t1_data", a_data, 8'hD4);
        chk("t1_valid", a_valid, 1);
        chk("t1_count", a_count, 1);
        for (int i = 0; i < 5; i++) tick();
        chk("t1_hold_data", a_data, 8'hD4);
        chk("t1_hold_id", a_id, 8'hA1);
        a_rdy = 1'b1;
        tick();
        a_rdy = 1'b0;
        chk("t1_pop_valid", a_valid, 0);
        chk("t1_pop_count", a_count, 0);
        chk("t1_pop_id", a_id, 0);
        chk("t1_pop_data", a_data, 0);
        $display("txn t1 single write/hold/pop done");

        // Fill to full then overflow
        for (int i = 1; i <= 4; i++) begin
            a_din = 32'(i); a_en = 1'b1;
            tick();
        end
        chk("t2_full", a_full, 1);
        chk("t2_count", a_count, 4);
        a_din = 32'h05;
        tick();
        a_en = 1'b0;
        chk("t2_ovf", a_ovf, 1);
        chk("t2_ovf_count", a_count, 4);
        chk("t2_ovf_head", a_data, 8'h01);
        a_rdy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("t2_drain", a_data, 64'(i));
            tick();
        end
        a_rdy = 1'b0;
        chk("t2_drained_valid", a_valid, 0);
        chk("t2_ovf_sticky", a_ovf, 1);
        $display("txn t2 fill/overflow/drain done");

        // Flush wins over a same-cycle write
        for (int i = 0; i < 3; i++) begin
            a_din = 32'h30 + 32'(i); a_en = 1'b1;
            tick();
        end
        chk("t5_pre_count", a_count, 3);
        a_din = 32'h77; a_flush = 1'b1;
        tick();
        a_en = 1'b0; a_flush = 1'b0;
        chk("t5_count", a_count, 0);
        chk("t5_ovf", a_ovf, 0);
        chk("t5_valid", a_valid, 0);
        tick();
        chk("t5_discarded", a_count, 0);
        $display("txn t5 flush vs write done");

        // Full with simultaneous write and pop
        for (int i = 0; i < 4; i++) begin
            a_din = 32'h10 + 32'(i); a_en = 1'b1;
            tick();
        end
        a_din = 32'h55; a_rdy = 1'b1;
        tick();
        a_en = 1'b0;
        chk("t3_count", a_count, 4);
        chk("t3_ovf", a_ovf, 0);
        chk("t3_d0", a_data, 8'h11); tick();
        chk("t3_d1", a_data, 8'h12); tick();
        chk("t3_d2", a_data, 8'h13); tick();
        chk("t3_d3", a_data, 8'h55); tick();
        chk("t3_empty", a_valid, 0);
        $display("txn t3 full write+pop done");

        // Streaming through ten words, wrapping the pointers
        a_en = 1'b1; a_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a_din = 32'h20 + 32'(i);
            tick();
            chk("t4_count", a_count, 1);
            chk("t4_data", a_data, 64'h20 + 64'(i));
        end
        a_en = 1'b0;
        tick();
        a_rdy = 1'b0;
        chk("t4_end_count", b_rst ? a_count : 3'd7, 0);
        $display("txn t4 streaming done");

        // Async reset mid-stream on the wide instance
        b_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            b_din = {8'hE0 + 8'(i), 8'h01, 8'h02, 32'hC0DE0000 + 32'(i)};
            tick();
        end
        b_en = 1'b0;
        chk("t6_count5", b_count, 5);
        chk("t6_head", b_data, 32'hC0DE0000);
        #3;
        b_rst = 1'b0;
        #1;
        chk("t6_rst_count", b_count, 0);
        chk("t6_rst_valid", b_valid, 0);
        chk("t6_rst_data", b_data, 0);
        chk("t6_rst_id", b_id, 0);
        tick();
        b_rst = 1'b1;
        chk("t6_post_count", b_count, 0);
        b_din = {8'h11, 8'h22, 8'h33, 32'hAABBCCDD}; b_en = 1'b1;
        tick();
        b_en = 1'b0;
        chk("t6_data", b_data, 32'hAABBCCDD);
        chk("t6_id", b_id, 8'h11);
        chk("t6_sel", b_sel, 8'h22);
        chk("t6_reg", b_reg, 8'h33);
        chk("t6_valid", b_valid, 1);
        chk("t6_count1", b_count, 1);
        $display("txn t6 async reset done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
